// File: rtl/pc_source_ctrl.sv
// Next-PC sequencer for the multicycle datapath: drives the PC-source mux select,
// PC/EPC write strobes and the exception-vector fetch through memory and MDR.
module pc_source_ctrl #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_kind,
  input  logic       branch_taken,
  input  logic [1:0] exc_code,
  output logic       req_ready,
  output logic [2:0] mux_pc_source_control,
  output logic       pc_write,
  output logic       epc_write,
  output logic       mem_read,
  output logic [7:0] vec_addr,
  output logic       mdr_write,
  output logic       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_SEQ, S_BR, S_JMP, S_JR, S_EPC_SAVE, S_VEC_RD, S_MDR_LD, S_PC_LD, S_ERET
  } state_t;

  localparam logic [2:0] KIND_BRANCH = 3'd1;
  localparam logic [2:0] KIND_JUMP   = 3'd2;
  localparam logic [2:0] KIND_JR     = 3'd3;
  localparam logic [2:0] KIND_EXC    = 3'd4;
  localparam logic [2:0] KIND_ERET   = 3'd5;

  localparam logic [2:0] SEL_ULA    = 3'b000;
  localparam logic [2:0] SEL_ALUOUT = 3'b001;
  localparam logic [2:0] SEL_CONCAT = 3'b010;
  localparam logic [2:0] SEL_MDR    = 3'b011;
  localparam logic [2:0] SEL_EPC    = 3'b100;

  localparam logic [3:0] CNT_INIT = 4'(MEM_WAIT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [1:0] r_code;
  logic [2:0] r_sel;
  logic       r_pc_write;
  logic       r_epc_write;
  logic       r_mem_read;
  logic [7:0] r_vec_addr;
  logic       r_mdr_write;
  logic       r_done;
  logic [7:0] w_vec;

  // Reserved exception code 3 shares the opcode-invalid vector.
  always_comb begin
    w_vec = 8'd253;
    case (r_code)
      2'd1:    w_vec = 8'd254;
      2'd2:    w_vec = 8'd255;
      default: w_vec = 8'd253;
    endcase
  end

  // Outputs are loaded on the edge that enters each state, so they are valid
  // for exactly the cycle spent in that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_code      <= '0;
      r_sel       <= SEL_ULA;
      r_pc_write  <= 1'b0;
      r_epc_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_vec_addr  <= '0;
      r_mdr_write <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_code <= exc_code;
            case (req_kind)
              KIND_BRANCH: begin
                r_state    <= S_BR;
                r_sel      <= SEL_ALUOUT;
                r_pc_write <= branch_taken;
                r_done     <= 1'b1;
              end
              KIND_JUMP: begin
                r_state    <= S_JMP;
                r_sel      <= SEL_CONCAT;
                r_pc_write <= 1'b1;
                r_done     <= 1'b1;
              end
              KIND_JR: begin
                r_state    <= S_JR;
                r_sel      <= SEL_ULA;
                r_pc_write <= 1'b1;
                r_done     <= 1'b1;
              end
              KIND_EXC: begin
                r_state     <= S_EPC_SAVE;
                r_epc_write <= 1'b1;
              end
              KIND_ERET: begin
                r_state    <= S_ERET;
                r_sel      <= SEL_EPC;
                r_pc_write <= 1'b1;
                r_done     <= 1'b1;
              end
              default: begin
                r_state    <= S_SEQ;
                r_sel      <= SEL_ULA;
                r_pc_write <= 1'b1;
                r_done     <= 1'b1;
              end
            endcase
          end
        end
        S_EPC_SAVE: begin
          r_state     <= S_VEC_RD;
          r_epc_write <= 1'b0;
          r_mem_read  <= 1'b1;
          r_vec_addr  <= w_vec;
          r_cnt       <= CNT_INIT;
        end
        S_VEC_RD: begin
          if (r_cnt == '0) begin
            r_state     <= S_MDR_LD;
            r_mem_read  <= 1'b0;
            r_mdr_write <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_MDR_LD: begin
          r_state     <= S_PC_LD;
          r_mdr_write <= 1'b0;
          r_vec_addr  <= '0;
          r_sel       <= SEL_MDR;
          r_pc_write  <= 1'b1;
          r_done      <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_sel       <= SEL_ULA;
          r_pc_write  <= 1'b0;
          r_epc_write <= 1'b0;
          r_mem_read  <= 1'b0;
          r_vec_addr  <= '0;
          r_mdr_write <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready             = (r_state == S_IDLE);
  assign mux_pc_source_control = r_sel;
  assign pc_write              = r_pc_write;
  assign epc_write             = r_epc_write;
  assign mem_read              = r_mem_read;
  assign vec_addr              = r_vec_addr;
  assign mdr_write             = r_mdr_write;
  assign done                  = r_done;

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed bench for pc_source_ctrl: a per-cycle expected-output queue is filled
// from a small request model and drained one entry per clock.
module tb_pc_source_ctrl;

  localparam int unsigned MEM_WAIT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_kind;
  logic       branch_taken;
  logic [1:0] exc_code;
  logic       req_ready;
  logic [2:0] mux_pc_source_control;
  logic       pc_write;
  logic       epc_write;
  logic       mem_read;
  logic [7:0] vec_addr;
  logic       mdr_write;
  logic       done;

  always #5 clk = ~clk;

  pc_source_ctrl #(.MEM_WAIT(MEM_WAIT)) u_dut (
    .clk                   (clk),
    .reset                 (reset),
    .req_valid             (req_valid),
    .req_kind              (req_kind),
    .branch_taken          (branch_taken),
    .exc_code              (exc_code),
    .req_ready             (req_ready),
    .mux_pc_source_control (mux_pc_source_control),
    .pc_write              (pc_write),
    .epc_write             (epc_write),
    .mem_read              (mem_read),
    .vec_addr              (vec_addr),
    .mdr_write             (mdr_write),
    .done                  (done)
  );

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [16:0] w_obs;

  // {ready, sel, pc_write, epc_write, mem_read, vec_addr, mdr_write, done}
  assign w_obs = {req_ready, mux_pc_source_control, pc_write, epc_write,
                  mem_read, vec_addr, mdr_write, done};

  function automatic logic [16:0] ov(logic rdy, logic [2:0] sel, logic pcw, logic epcw,
                                     logic mr, logic [7:0] va, logic mdr, logic dn);
    return {rdy, sel, pcw, epcw, mr, va, mdr, dn};
  endfunction

  function automatic logic [7:0] vec_of(logic [1:0] code);
    if (code == 2'd1) return 8'd254;
    if (code == 2'd2) return 8'd255;
    return 8'd253;
  endfunction

  task automatic chk(string tag, logic [16:0] obs, logic [16:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [16:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, w_obs, e.v);
    end
  endtask

  // Expected outputs for cycles +1.. after an accept, plus the idle cycle that follows.
  task automatic model(logic [2:0] kind, logic taken, logic [1:0] code, string tag);
    case (kind)
      3'd1: push({tag, "_br"}, ov(1'b0, 3'b001, taken, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
      3'd2: push({tag, "_jmp"}, ov(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
      3'd4: begin
        push({tag, "_epc"}, ov(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0));
        for (int unsigned i = 0; i < MEM_WAIT; i++)
          push({tag, "_vec"}, ov(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, vec_of(code), 1'b0, 1'b0));
        push({tag, "_mdr"}, ov(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, vec_of(code), 1'b1, 1'b0));
        push({tag, "_pcld"}, ov(1'b0, 3'b011, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
      end
      3'd5: push({tag, "_eret"}, ov(1'b0, 3'b100, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
      default: push({tag, "_seq"}, ov(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1));
    endcase
    push({tag, "_idle"}, ov(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
  endtask

  // Busy-cycle noise scrambles every request input; all of it must be ignored.
  task automatic do_req(logic [2:0] kind, logic taken, logic [1:0] code, string tag,
                        bit hold, bit noise);
    int n;
    req_valid    = 1'b1;
    req_kind     = kind;
    branch_taken = taken;
    exc_code     = code;
    model(kind, taken, code, tag);
    n = sb.size();
    step();
    if (!hold) req_valid = 1'b0;
    for (int i = 1; i < n; i++) begin
      if (noise) begin
        req_valid    = 1'($urandom_range(0, 1));
        req_kind     = 3'($urandom_range(0, 7));
        exc_code     = 2'($urandom_range(0, 3));
        branch_taken = ~branch_taken;
      end
      step();
    end
    if (!hold) req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b0;
    req_valid    = 1'b0;
    req_kind     = 3'd0;
    branch_taken = 1'b0;
    exc_code     = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", w_obs, ov(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      push("post_reset_idle", ov(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) step();

    do_req(3'd0, 1'b0, 2'd0, "b2b_a", 1'b1, 1'b0);
    do_req(3'd2, 1'b0, 2'd0, "b2b_b", 1'b0, 1'b0);
    do_req(3'd1, 1'b0, 2'd0, "br_nt", 1'b0, 1'b1);
    do_req(3'd1, 1'b1, 2'd0, "br_t", 1'b0, 1'b1);
    do_req(3'd3, 1'b0, 2'd0, "jr", 1'b0, 1'b0);
    do_req(3'd7, 1'b0, 2'd0, "rsv7", 1'b0, 1'b0);
    do_req(3'd4, 1'b0, 2'd2, "exc2", 1'b0, 1'b1);
    do_req(3'd4, 1'b0, 2'd0, "exc0", 1'b0, 1'b0);
    do_req(3'd5, 1'b0, 2'd0, "eret", 1'b0, 1'b0);
    do_req(3'd4, 1'b0, 2'd3, "exc3", 1'b0, 1'b1);

    // Reset asserted partway through the second VEC_RD cycle.
    req_valid = 1'b1;
    req_kind  = 3'd4;
    exc_code  = 2'd1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rst_exc_epc", w_obs, ov(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("rst_exc_vec1", w_obs, ov(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'd254, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("rst_exc_vec2", w_obs, ov(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 8'd254, 1'b0, 1'b0));
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async", w_obs, ov(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    chk("rst_hold", w_obs, ov(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      push("rst_release_idle", ov(1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) step();
    do_req(3'd0, 1'b0, 2'd0, "post_rst", 1'b0, 1'b0);

    n_assert++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_source_ctrl.md
# pc_source_ctrl

Sequencer that drives the select input of the PC-source multiplexer, plus the matching PC/EPC write strobes, in the multicycle CPU datapath. The main control unit hands it one "next-PC" request per instruction: sequential, branch, jump, jump-register, exception or exception-return. The block runs the cycle-exact sequence for that request, including the vector-fetch through memory and MDR that exceptions need, and reports completion. It is the producer side of the 3-bit PC-source select encoding.

## Interface
- MEM_WAIT, 2: cycles `mem_read` is held during the exception-vector fetch (1..15).
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_kind  in  3  0 SEQ, 1 BRANCH, 2 JUMP, 3 JR, 4 EXC, 5 ERET; 6/7 reserved.
- branch_taken  in  1  branch condition result; sampled with the request.
- exc_code  in  2  0 opcode-invalid, 1 overflow, 2 div-by-zero, 3 reserved; sampled with the request.
- req_ready  out  1  block idle and able to accept.
- mux_pc_source_control  out  3  select: 000 ULA_out, 001 AluOut_out, 010 concatena_28_32_out, 011 mdr_out, 100 epc_out.
- pc_write  out  1  PC load strobe.
- epc_write  out  1  EPC load strobe.
- mem_read  out  1  memory read for the vector fetch.
- vec_addr  out  8  byte address of the vector fetch.
- mdr_write  out  1  MDR load strobe.
- done  out  1  one-cycle pulse when the request completes.

## Operation
- States: IDLE, SEQ, BR, JMP, JR, EPC_SAVE, VEC_RD, MDR_LD, PC_LD, ERET.
- IDLE: req_ready=1. All strobes are 0. Select is 000.
- Accept: req_valid && req_ready at a rising edge. Latch req_kind, branch_taken and exc_code, then leave IDLE.
- SEQ: select 000, pc_write=1, done=1, then IDLE.
- BR: select 001, pc_write=branch_taken (latched), done=1, then IDLE.
  - done pulses even when the branch is not taken.
- JMP: select 010, pc_write=1, done=1, then IDLE.
- JR: select 000 (register value routed through the ALU), pc_write=1, done=1, then IDLE.
- ERET: select 100, pc_write=1, done=1, then IDLE.
- EXC sequence:
  - EPC_SAVE (1 cycle): epc_write=1.
  - VEC_RD (MEM_WAIT cycles): mem_read=1. vec_addr = 253 + exc_code, with reserved code 3 mapped to 253. A down-counter loaded with MEM_WAIT-1 times this state.
  - MDR_LD (1 cycle): mdr_write=1.
  - PC_LD (1 cycle): select 011, pc_write=1, done=1, then IDLE.
- vec_addr is held stable from entry to VEC_RD until exit from MDR_LD, and reads 0 otherwise.
- Reserved req_kind 6/7: treated as SEQ.
- req_ready=0 in every non-IDLE state. req_valid asserted while busy is ignored and is not queued.
- At most one of pc_write and epc_write is ever high. pc_write is never high with a select other than the one listed for the current state.
- Reset (reset=0), at any time including mid-sequence: immediately force IDLE, clear the counter and latches, and drive all outputs to their reset values. No partial strobe may follow the release of reset.

## Timing
- All outputs are registered / decoded from state. There is no combinational path from req_* to outputs, except req_ready, which is state-only.
- Reset values: req_ready=1, mux_pc_source_control=000, pc_write=0, epc_write=0, mem_read=0, vec_addr=0, mdr_write=0, done=0.
- Latency counts from the accept edge to the done cycle:
  - SEQ/BR/JMP/JR/ERET: done in cycle +1, with req_ready back in cycle +2.
  - EXC: EPC_SAVE in cycle +1, VEC_RD in +2..+1+MEM_WAIT, MDR_LD in +2+MEM_WAIT, PC_LD/done in +3+MEM_WAIT.
  - Total EXC occupancy is 3+MEM_WAIT cycles.
- Back-to-back throughput for single-cycle kinds is one request every 2 cycles.
- Select value is valid in the same cycle as pc_write. The PC captures it on the following edge.

## Test plan
- Reset held low, then released with req_valid=0: all outputs at reset values; req_ready=1 for ≥3 cycles.
- SEQ then JMP back-to-back (req_valid held high):
  - Cycle +1: select 000, pc_write=1, done=1.
  - Cycle +2: req_ready=1 and JMP accepted.
  - Cycle +3: select 010, pc_write=1.
- BRANCH with branch_taken=0, then with 1:
  - Not taken: select 001, pc_write=0, done=1.
  - Taken: select 001, pc_write=1.
  - Toggling branch_taken after accept has no effect.
- EXC with exc_code=2, MEM_WAIT=2:
  - Cycle +1: epc_write=1.
  - Cycles +2..+3: mem_read=1, vec_addr=255.
  - Cycle +4: mdr_write=1.
  - Cycle +5: select 011, pc_write=1, done=1.
  - req_valid pulses during cycles +1..+5 are ignored.
- ERET, and EXC with exc_code=3:
  - ERET: select 100, pc_write=1 in cycle +1.
  - exc_code=3: vec_addr=253 during VEC_RD.
- Reset asserted in the second VEC_RD cycle of an EXC:
  - Outputs go to reset values asynchronously.
  - No mdr_write or pc_write follows.
  - A SEQ accepted after release completes in 1 cycle.
